// File: rtl/rf_pkg.sv
// Shared defaults and types for the register file with pending-write scoreboard.
package rf_pkg;

    localparam int unsigned XLEN_DEF    = 32;
    localparam int unsigned NREG_DEF    = 32;
    localparam int unsigned NRD_DEF     = 2;
    localparam int unsigned MAXPEND_DEF = 3;
    localparam int unsigned AW_DEF      = $clog2(NREG_DEF);
    localparam int unsigned CNT_W       = $clog2(MAXPEND_DEF + 1);

    typedef logic [AW_DEF-1:0] regaddr_t;
    typedef logic [CNT_W-1:0]  pend_cnt_t;

    localparam regaddr_t ZERO_REG = '0;

endpackage

// File: rtl/rf_pend_counter.sv
// One pending-write counter: saturating up/down with underflow/overflow error pulse.
module rf_pend_counter #(
    parameter int unsigned MAXPEND = 3,
    parameter int unsigned CW      = $clog2(MAXPEND + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc_req,
    input  logic [1:0] dec,
    output logic       ready,
    output logic       busy,
    output logic       err
);

    localparam int unsigned   SW  = ((CW > 2) ? CW : 2) + 1;
    localparam logic [CW-1:0] CAP = CW'(MAXPEND);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [SW-1:0] sum;
    logic [SW-1:0] dec_w;
    logic          inc;

    always_comb begin
        ready = (cnt_q < CAP);
        inc   = inc_req & ready;
        sum   = SW'(cnt_q) + SW'(inc);
        dec_w = SW'(dec);
        err   = inc_req & ~ready;
        cnt_d = CW'(sum - dec_w);
        if (dec_w > sum) begin
            cnt_d = '0;
            err   = 1'b1;
        end
        // Busy ignores this cycle's issue so a retiring producer frees its consumer at once.
        busy = (SW'(cnt_q) > dec_w);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with write-through bypass and per-register pending-write scoreboard.
module regfile_scoreboard
    import rf_pkg::*;
#(
    parameter int unsigned XLEN    = XLEN_DEF,
    parameter int unsigned NREG    = NREG_DEF,
    parameter int unsigned NRD     = NRD_DEF,
    parameter int unsigned MAXPEND = MAXPEND_DEF,
    parameter bit          X0_ZERO = 1'b1,
    parameter int unsigned AW      = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]    rd_busy,
    input  logic              issue_valid,
    input  logic [AW-1:0]     issue_rd,
    output logic              issue_ready,
    input  logic              wb_valid,
    input  logic [AW-1:0]     wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              kill_valid,
    input  logic [AW-1:0]     kill_rd,
    output logic              sb_err
);

    localparam logic [AW-1:0] R0 = AW'(ZERO_REG);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy_vec;
    logic [NREG-1:0] ready_vec;
    logic [NREG-1:0] err_vec;
    logic            sb_err_q;
    logic            wb_en;

    assign wb_en = wb_valid && !(X0_ZERO && (wb_rd == R0));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
        end else if (wb_en) begin
            regs[wb_rd] <= wb_data;
        end
    end

    for (genvar r = 0; r < NREG; r++) begin : g_pend
        logic       inc_req;
        logic [1:0] dec;

        if (X0_ZERO && (r == 0)) begin : g_zero
            assign inc_req = 1'b0;
            assign dec     = 2'd0;
        end else begin : g_live
            logic wb_hit;
            logic kill_hit;
            assign inc_req  = issue_valid && (issue_rd == AW'(r));
            assign wb_hit   = wb_valid && (wb_rd == AW'(r));
            assign kill_hit = kill_valid && (kill_rd == AW'(r));
            assign dec      = {1'b0, wb_hit} + {1'b0, kill_hit};
        end

        rf_pend_counter #(
            .MAXPEND (MAXPEND)
        ) u_cnt (
            .clk     (clk),
            .reset   (reset),
            .inc_req (inc_req),
            .dec     (dec),
            .ready   (ready_vec[r]),
            .busy    (busy_vec[r]),
            .err     (err_vec[r])
        );
    end

    assign issue_ready = ready_vec[issue_rd];

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            logic [AW-1:0] a;
            a = rd_addr[i*AW +: AW];
            if (X0_ZERO && (a == R0)) begin
                rd_data[i*XLEN +: XLEN] = '0;
            end else if (wb_valid && (wb_rd == a)) begin
                rd_data[i*XLEN +: XLEN] = wb_data;
            end else begin
                rd_data[i*XLEN +: XLEN] = regs[a];
            end
            rd_busy[i] = busy_vec[a];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sb_err_q <= 1'b0;
        end else begin
            sb_err_q <= sb_err_q | (|err_vec);
        end
    end

    assign sb_err = sb_err_q;

endmodule
